instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Producer side of the fetch->decode interface: owns the PC and issues instruction-memory reads.
// - Buffers fetched words with their PCs and presents {pc_o, instr_o} to the decoder under a valid/ready handshake.
// - Takes redirects from decode/ALU (branch, JAL, JALR target) and flushes everything fetched down the wrong path.
// PARAMETERS
// - ADDRESS_BITS  16   width of the PC and instruction-memory byte address
// - RESET_PC      0    first fetch address after reset; word aligned
// - FIFO_DEPTH    2    prefetch buffer entries; power of two, >= 2
// PORTS
// - clk            in   1             single clock, all state on rising edge
// - rst_n          in   1             asynchronous, active-low reset
// - imem_req_o     out  1             read request to instruction memory
// - imem_addr_o    out  ADDRESS_BITS  byte address; bits [1:0] always 0
// - imem_gnt_i     in   1             memory accepts the request this cycle
// - imem_rvalid_i  in   1             read data valid
// - imem_rdata_i   in   32            instruction word
// - instr_valid_o  out  1             FIFO head valid toward decode
// - instr_ready_i  in   1             decode consumes the head this cycle
// - instr_o        out  32            instruction at FIFO head
// - pc_o           out  ADDRESS_BITS  PC of instr_o
// - redirect_i     in   1             take target_pc_i as the next fetch PC
// - target_pc_i    in   ADDRESS_BITS  redirect target; bits [1:0] ignored, treated as 0
// BEHAVIOUR
// - Reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0.
//   Internal state: fetch_pc=RESET_PC, FIFO empty, no outstanding read, FSM=IDLE.
// - Reset asserted mid-operation clears all state. A response still in flight is never written afterwards.
// - Memory protocol
//   - At most one outstanding read.
//   - A request is held until imem_gnt_i. The address may change while the request is ungranted (redirect only).
//   - imem_rvalid_i comes at least 1 cycle after the grant.
// - FSM
//   - IDLE   -> REQ    when fifo_count + outstanding < FIFO_DEPTH
//   - REQ    -> WAIT   on imem_gnt_i; fetch_pc += 4 (wraps mod 2^ADDRESS_BITS); the granted PC is saved in req_pc
//   - WAIT   -> IDLE   on imem_rvalid_i; {req_pc, imem_rdata_i} is pushed into the FIFO
//   - WAIT   -> DISCARD on redirect_i (response still pending)
//   - DISCARD -> IDLE  on imem_rvalid_i; the data is dropped
// - Throughput: one instruction per 3 cycles with single-cycle grant and 1-cycle rvalid latency.
// - Decode handshake
//   - instr_valid_o = FIFO not empty; outputs are taken combinationally from the head.
//   - The head is popped on instr_valid_o & instr_ready_i.
//   - instr_o and pc_o stay stable while valid and not ready.
// - Redirect
//   - The FIFO is flushed in the same cycle; instr_valid_o=0 next cycle.
//   - fetch_pc <= {target_pc_i[AB-1:2], 2'b00}.
//   - A pop in the same cycle is ignored: redirect wins.
//   - REQ ungranted: the request stays up and imem_addr_o shows the new target next cycle.
//   - REQ granted in the redirect cycle: go to DISCARD.
//   - rvalid in the same cycle as the redirect: the data is dropped.
//   - Back-to-back redirects: the last one wins.
// - Simultaneous push and pop with the FIFO full is legal; count is unchanged. Push when full cannot occur due to the credit rule.
// - Minimum redirect-to-first-valid latency: 3 cycles (req+gnt, rvalid, push).
// STRUCTURE
// - Shared header riscv_defines.vh holds:
//   - opcode localparams already shared with the decoder
//   - FETCH_IDLE/REQ/WAIT/DISCARD state encodings (2 bits)
//   - RISCV_NOP = 32'h00000013
// - Sub-module fetch_fifo: sync FIFO with width 32+ADDRESS_BITS, depth FIFO_DEPTH, and push/pop/flush/count.
// - The top level holds the FSM, fetch_pc, req_pc and the credit logic.
// TESTING
// - Reset, then memory with gnt=1 and rvalid 1 cycle later, ready=1 -> pc_o sequence 0,4,8; instr_o matches the memory image.
// - ready=0 for 10 cycles -> exactly FIFO_DEPTH words buffered, imem_req_o=0 afterwards, pc_o/instr_o held stable.
// - Redirect to 0x0102 while WAIT at PC 0x10 -> the 0x10 response is discarded; next valid is pc_o=0x0100.
// - Redirect while gnt=0 (stalled request) -> imem_addr_o changes to the target next cycle, req stays high; granted addr = target.
// - fetch_pc=0xFFFC with ADDRESS_BITS=16 -> next fetch address 0x0000.
// - rst_n pulsed low while WAIT, late rvalid after reset -> FIFO stays empty; first fetch is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding and the fixed instruction word width.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    // Instruction words are always 32 bits, independent of the PC width.
    localparam int unsigned INSTR_BITS = 32;

    // Fetch FSM. FETCH_DISCARD means a read is still outstanding but its
    // data belongs to a path that a redirect has already abandoned.
    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_WAIT    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_fifo
// Synchronous prefetch FIFO holding {pc, instruction} entries.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write data_i at the tail (ignored when full and not popping)
//   data_i       entry to write
//   pop_i        drop the head entry (ignored when empty)
//   flush_i      empty the FIFO; wins over push and pop in the same cycle
//   data_o       head entry, combinational; all zeros when empty
//   empty_o      FIFO holds no entries
//   count_o      number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_unit_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
    localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q, count_d;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_FULL);

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle, so the slot it frees is the one being written.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full || do_pop) && !flush_i;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale contents are
    // never visible because data_o is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Owns the program counter, issues one instruction-memory read at a time and
// hands fetched {pc, instruction} pairs to decode through a small prefetch
// FIFO. Redirects from decode/ALU flush the FIFO and restart fetching at the
// target; a read already in flight at that moment is completed and dropped.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_req_o      read request, held until imem_gnt_i
//   imem_addr_o     word-aligned byte address of the request
//   imem_gnt_i      memory accepts the request this cycle
//   imem_rvalid_i   read data valid (at least one cycle after the grant)
//   imem_rdata_i    instruction word
//   instr_valid_o   FIFO head valid toward decode
//   instr_ready_i   decode consumes the head this cycle
//   instr_o, pc_o   instruction at the FIFO head and its PC
//   redirect_i      restart fetching at target_pc_i (bits [1:0] ignored)
//   target_pc_i     redirect target
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned                ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0]    RESET_PC     = '0,
    parameter int unsigned                FIFO_DEPTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req_o,
    output logic [ADDRESS_BITS-1:0]   imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [INSTR_BITS-1:0]     imem_rdata_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [INSTR_BITS-1:0]     instr_o,
    output logic [ADDRESS_BITS-1:0]   pc_o,
    input  logic                      redirect_i,
    input  logic [ADDRESS_BITS-1:0]   target_pc_i
);

    localparam int unsigned ENTRY_BITS = INSTR_BITS + ADDRESS_BITS;
    localparam int unsigned CNT_BITS   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned USE_BITS   = CNT_BITS + 1;
    localparam logic [ADDRESS_BITS-1:0] PC_STEP = ADDRESS_BITS'(4);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_BITS-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0]  req_pc_q, req_pc_d;
    logic [ADDRESS_BITS-1:0]  target_aligned;

    logic [CNT_BITS-1:0]      fifo_count;
    logic [CNT_BITS-1:0]      fifo_level;
    logic [USE_BITS-1:0]      in_use;
    logic                     outstanding;
    logic                     credit;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic [ENTRY_BITS-1:0]    fifo_head;

    assign target_aligned = {target_pc_i[ADDRESS_BITS-1:2], 2'b00};

    // Credit: buffered words plus the read in flight must leave room for one
    // more word, so a response can always be pushed without back-pressure.
    // A redirect empties the FIFO this cycle, so it frees all buffered slots.
    assign outstanding = (state_q == FETCH_WAIT) || (state_q == FETCH_DISCARD);
    assign fifo_level  = redirect_i ? '0 : fifo_count;
    assign in_use      = USE_BITS'(fifo_level) + USE_BITS'(outstanding);
    assign credit      = (in_use < USE_BITS'(FIFO_DEPTH));

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        fifo_push  = 1'b0;

        unique case (state_q)
            FETCH_IDLE: begin
                if (credit) state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_gnt_i) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    // The granted read now belongs to the abandoned path.
                    state_d    = redirect_i ? FETCH_DISCARD : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d   = FETCH_IDLE;
                    fifo_push = !redirect_i;
                end else if (redirect_i) begin
                    state_d = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (imem_rvalid_i) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        // A redirect overrides the sequential increment in any state; an
        // ungranted request simply re-presents the new address next cycle.
        if (redirect_i) fetch_pc_d = target_aligned;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign imem_req_o  = (state_q == FETCH_REQ);
    assign imem_addr_o = fetch_pc_q;

    // Redirect wins over a same-cycle pop: the flush discards the head anyway.
    assign fifo_pop = instr_valid_o && instr_ready_i && !redirect_i;

    instr_fetch_unit_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  ({req_pc_q, imem_rdata_i}),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_valid_o     = !fifo_empty;
    assign {pc_o, instr_o}   = fifo_head;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Drives instr_fetch_unit with a behavioural instruction memory (random grant,
// random response latency) and a randomised decoder/redirect source. The
// reference model is the program-order view of fetch: decode must see
// consecutive PCs starting at RESET_PC or at the last redirect target, each
// carrying the memory image word for that PC, with interface-level protocol
// rules checked every cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned AB       = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [15:0] pc_o;
    logic        redirect_i;
    logic [15:0] target_pc_i;

    instr_fetch_unit #(
        .ADDRESS_BITS (AB),
        .RESET_PC     (RESET_PC),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .redirect_i    (redirect_i),
        .target_pc_i   (target_pc_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory image: every address holds a distinct, address-derived word.
    function automatic logic [31:0] img(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    // Stimulus knobs
    int gnt_pct   = 100;
    int ready_pct = 100;
    int redir_pm  = 0;      // redirects per thousand cycles
    int lat_min   = 1;
    int lat_max   = 1;
    bit force_redir = 1'b0;
    logic [15:0] force_target = '0;
    bit stale_ok = 1'b0;    // a pre-reset response may still be in flight

    // Memory model state
    bit          mem_busy  = 1'b0;
    logic [15:0] mem_addr  = '0;
    int          mem_delay = 0;

    // Reference model / bookkeeping
    logic [15:0] exp_pc = RESET_PC;
    logic [15:0] last_pc = '0;
    int cons_cnt = 0, rvalid_cnt = 0, grant_cnt = 0, cyc = 0;
    int last_cons_cyc = 0, prev_cons_cyc = 0;

    bit          prev_stall = 1'b0, prev_redirect = 1'b0, prev_hold = 1'b0;
    logic [15:0] prev_addr = '0, prev_target = '0, prev_pc = '0;
    logic [31:0] prev_instr = '0;

    // One clock cycle: observe at the falling edge, drive the inputs for the
    // next rising edge, then return 1 time unit after that edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (prev_stall) begin
                check("req_held", imem_req_o, 1);
                check("addr_held", imem_addr_o, prev_redirect ? prev_target : prev_addr);
            end
            if (prev_redirect) begin
                check("flush_valid", instr_valid_o, 0);
            end else if (prev_hold) begin
                check("hold_valid", instr_valid_o, 1);
                check("hold_pc", pc_o, prev_pc);
                check("hold_instr", instr_o, prev_instr);
            end
            if (imem_req_o) begin
                check("addr_align", imem_addr_o[1:0], 2'b00);
                if (!stale_ok) check("one_outstanding", mem_busy, 0);
            end
        end

        // Memory response
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom();
        if (mem_busy) begin
            mem_delay--;
            if (mem_delay == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = img(mem_addr);
                mem_busy      = 1'b0;
                rvalid_cnt++;
            end
        end

        // Memory grant
        imem_gnt_i = 1'b0;
        if (rst_n && imem_req_o && !mem_busy && !imem_rvalid_i &&
            ($urandom_range(0, 99) < gnt_pct)) begin
            imem_gnt_i = 1'b1;
            mem_busy   = 1'b1;
            mem_addr   = imem_addr_o;
            mem_delay  = $urandom_range(lat_min, lat_max);
            grant_cnt++;
        end

        // Decoder and redirect source
        instr_ready_i = rst_n && ($urandom_range(0, 99) < ready_pct);
        redirect_i    = 1'b0;
        target_pc_i   = 16'($urandom());
        if (rst_n) begin
            if (force_redir) begin
                redirect_i  = 1'b1;
                target_pc_i = force_target;
                force_redir = 1'b0;
            end else if (redir_pm != 0 && $urandom_range(0, 999) < redir_pm) begin
                redirect_i = 1'b1;
            end
        end

        // Scoreboard: a consumed instruction must be the next one in order.
        if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
            check("pc", pc_o, exp_pc);
            check("instr", instr_o, img(exp_pc));
            last_pc       = pc_o;
            prev_cons_cyc = last_cons_cyc;
            last_cons_cyc = cyc;
            cons_cnt++;
            exp_pc = exp_pc + 16'd4;
        end
        if (redirect_i) exp_pc = {target_pc_i[15:2], 2'b00};

        prev_stall    = rst_n && imem_req_o && !imem_gnt_i;
        prev_addr     = imem_addr_o;
        prev_redirect = redirect_i;
        prev_target   = {target_pc_i[15:2], 2'b00};
        prev_hold     = rst_n && instr_valid_o && !instr_ready_i && !redirect_i;
        prev_pc       = pc_o;
        prev_instr    = instr_o;

        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit keep_mem);
        rst_n = 1'b0;
        #1;
        if (!keep_mem) mem_busy = 1'b0;
        prev_stall    = 1'b0;
        prev_redirect = 1'b0;
        prev_hold     = 1'b0;
        exp_pc        = RESET_PC;
        tick();
        check("rst_req", imem_req_o, 0);
        check("rst_addr", imem_addr_o, RESET_PC);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_pc", pc_o, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_cons(input int n, input int budget, input string tag);
        int goal;
        int k;
        goal = cons_cnt + n;
        k    = 0;
        while (cons_cnt < goal && k < budget) begin
            tick();
            k++;
        end
        if (cons_cnt < goal) check(tag, 0, 1);
    endtask

    initial begin
        int base;
        int k;

        rst_n         = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        target_pc_i   = '0;

        // Sequential fetch, single-cycle grant, one-cycle latency.
        apply_reset(1'b0);
        wait_cons(3, 50, "timeout_seq");
        check("seq_third_pc", last_pc, 16'h0008);
        wait_cons(1, 20, "timeout_tp1");
        check("throughput_gap", last_cons_cyc - prev_cons_cyc, 3);
        wait_cons(1, 20, "timeout_tp2");
        check("throughput_gap", last_cons_cyc - prev_cons_cyc, 3);

        // Decoder stalled: FIFO fills to its depth and fetching stops.
        apply_reset(1'b0);
        ready_pct = 0;
        base = rvalid_cnt;
        repeat (12) tick();
        check("fill_count", rvalid_cnt - base, DEPTH);
        check("fill_req", imem_req_o, 0);
        check("fill_valid", instr_valid_o, 1);
        check("fill_pc", pc_o, RESET_PC);
        check("fill_instr", instr_o, img(RESET_PC));
        ready_pct = 100;
        wait_cons(2, 20, "timeout_drain");

        // Redirect while the read for 0x10 is in flight.
        apply_reset(1'b0);
        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (!(mem_busy && mem_addr == 16'h0010) && k < 100) begin
            tick();
            k++;
        end
        if (!(mem_busy && mem_addr == 16'h0010)) check("timeout_wait10", 0, 1);
        force_redir  = 1'b1;
        force_target = 16'h0102;
        tick();
        wait_cons(1, 40, "timeout_redir");
        check("redir_first_pc", last_pc, 16'h0100);

        // Redirect while the request is stalled on the grant.
        apply_reset(1'b0);
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 0;
        k = 0;
        while (!imem_req_o && k < 10) begin
            tick();
            k++;
        end
        if (!imem_req_o) check("timeout_req", 0, 1);
        force_redir  = 1'b1;
        force_target = 16'h0ABE;
        tick();
        check("stall_redir_addr", imem_addr_o, 16'h0ABC);
        check("stall_redir_req", imem_req_o, 1);
        gnt_pct = 100;
        base = grant_cnt;
        k = 0;
        while (grant_cnt == base && k < 10) begin
            tick();
            k++;
        end
        check("stall_grant_addr", mem_addr, 16'h0ABC);
        wait_cons(1, 20, "timeout_stall");
        check("stall_first_pc", last_pc, 16'h0ABC);

        // Address wrap at the top of the PC space.
        force_redir  = 1'b1;
        force_target = 16'hFFFE;
        tick();
        wait_cons(2, 40, "timeout_wrap");
        check("wrap_pc", last_pc, 16'h0000);

        // Reset pulsed while a read is outstanding; its late response must
        // never reach decode.
        lat_min = 6;
        lat_max = 6;
        k = 0;
        while (!mem_busy && k < 20) begin
            tick();
            k++;
        end
        if (!mem_busy) check("timeout_busy", 0, 1);
        gnt_pct  = 0;
        stale_ok = 1'b1;
        apply_reset(1'b1);
        k = 0;
        while (mem_busy && k < 20) begin
            tick();
            k++;
        end
        repeat (2) tick();
        check("stale_dropped", instr_valid_o, 0);
        stale_ok = 1'b0;
        lat_min  = 1;
        lat_max  = 1;
        gnt_pct  = 100;
        wait_cons(1, 20, "timeout_after_rst");
        check("after_rst_pc", last_pc, RESET_PC);

        // Randomised traffic against the program-order model.
        gnt_pct   = 60;
        ready_pct = 70;
        redir_pm  = 30;
        lat_min   = 1;
        lat_max   = 4;
        base = cons_cnt;
        repeat (4000) tick();
        check("random_progress", (cons_cnt - base) > 100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
